trx_switch_sequencer: RTL and testbench

Sequences RX/TX switching and RF relay changes (attenuator, preamp, BPF, LPF) requested over the STM32 parameter bus, so that relays never switch under live signal.
- Sits between the STM32 parameter registers and the board relay/TR pins.
- Enforces mute → apply → settle ordering.
- Gates the RX IQ path (rx_mute) and the TX DAC path (tx_gate).

---
 rtl/trx_seq_pkg.sv | 39 +++
 rtl/trx_seq_timer.sv | 42 ++++
 rtl/trx_switch_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_trx_switch_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trx_seq_pkg.sv
// Shared types for the TR switch sequencer: state encoding, relay configuration
// bundle and the helper that forms the requested relay word for a given mode.
package trx_seq_pkg;

  localparam int ATT_W   = 6;
  localparam int BPF_W   = 4;
  localparam int LPF_W   = 3;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RX_ACT = 3'd0,
    ST_TX_ACT = 3'd1,
    ST_MUTE   = 3'd2,
    ST_APPLY  = 3'd3,
    ST_SETTLE = 3'd4
  } state_e;

  typedef struct packed {
    logic [ATT_W-1:0] att;
    logic             preamp;
    logic [BPF_W-1:0] bpf;
    logic [LPF_W-1:0] lpf;
  } relay_cfg_t;

  // The preamp must never be energised while transmitting.
  function automatic relay_cfg_t req_cfg(input logic [ATT_W-1:0] att,
                                         input logic             preamp,
                                         input logic [BPF_W-1:0] bpf,
                                         input logic [LPF_W-1:0] lpf,
                                         input logic             to_tx);
    relay_cfg_t c;
    c.att    = att;
    c.preamp = preamp & ~to_tx;
    c.bpf    = bpf;
    c.lpf    = lpf;
    return c;
  endfunction

endpackage

// File: rtl/trx_seq_timer.sv
// Loadable down-counter shared by the MUTE and SETTLE phases; done pulses for
// one cycle when a loaded count has fully elapsed (load value N gives N+1 cycles).
module trx_seq_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    cnt_d = cnt_q;
    run_d = run_q;
    if (load) begin
      cnt_d = load_val;
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) run_d = 1'b0;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    if (!reset_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done = run_q && (cnt_q == '0);

endmodule

// File: rtl/trx_switch_sequencer.sv
// Mute -> apply -> settle sequencer for the TR relay and RF relay bank.
// Optional TX watchdog enabled by defining TRX_TX_WATCHDOG_EN.
module trx_switch_sequencer
  import trx_seq_pkg::*;
#(
  parameter int MUTE_CYC       = 256,
  parameter int SETTLE_CYC     = 4096,
  parameter int CNT_W          = 16,
  parameter int TX_TIMEOUT_CYC = 600000000
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             tx_req,
  input  logic [ATT_W-1:0] cfg_att,
  input  logic             cfg_preamp,
  input  logic [BPF_W-1:0] cfg_bpf,
  input  logic [LPF_W-1:0] cfg_lpf,
  output logic             rx,
  output logic             tx,
  output logic [ATT_W-1:0] att_out,
  output logic             preamp_out,
  output logic [BPF_W-1:0] bpf_out,
  output logic [LPF_W-1:0] lpf_out,
  output logic             rx_mute,
  output logic             tx_gate,
  output logic             busy,
  output logic             tx_timeout,
  output logic [STATE_W-1:0] state_debug
);

  state_e     state_q, state_d;
  logic       target_q, target_d;
  logic       rx_q, rx_d, tx_q, tx_d;
  relay_cfg_t applied_q, applied_d;
  logic       rx_mute_q, rx_mute_d;
  logic       tx_gate_q, tx_gate_d;
  logic       busy_q, busy_d;

  logic             tx_req_eff;
  logic             wd_hit;
  logic             timer_load, timer_done;
  logic [CNT_W-1:0] timer_val;
  relay_cfg_t       cfg_rx, cfg_tx, cfg_tgt;

`ifdef TRX_TX_WATCHDOG_EN
  localparam int WD_W = $clog2(TX_TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;

  always_comb begin
    wd_hit    = (state_q == ST_TX_ACT) && (wd_q == WD_W'(TX_TIMEOUT_CYC - 1));
    wd_d      = (state_q == ST_TX_ACT) ? wd_q + WD_W'(1) : '0;
    timeout_d = wd_hit | (timeout_q & tx_req);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  // A tripped watchdog holds the radio in RX until the host drops its request.
  assign tx_req_eff = tx_req & ~timeout_q;
  assign tx_timeout = timeout_q;
`else
  assign wd_hit     = 1'b0;
  assign tx_req_eff = tx_req;
  assign tx_timeout = 1'b0;
`endif

  assign cfg_rx  = req_cfg(cfg_att, cfg_preamp, cfg_bpf, cfg_lpf, 1'b0);
  assign cfg_tx  = req_cfg(cfg_att, cfg_preamp, cfg_bpf, cfg_lpf, 1'b1);
  assign cfg_tgt = tx_req_eff ? cfg_tx : cfg_rx;

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    applied_d = applied_q;

    unique case (state_q)
      ST_RX_ACT: begin
        if (tx_req_eff) begin
          state_d  = ST_MUTE;
          target_d = 1'b1;
        end else if (cfg_rx != applied_q) begin
          state_d  = ST_MUTE;
          target_d = 1'b0;
        end
      end
      ST_TX_ACT: begin
        if (wd_hit || !tx_req_eff) begin
          state_d  = ST_MUTE;
          target_d = 1'b0;
        end else if (cfg_tx != applied_q) begin
          state_d  = ST_MUTE;
          target_d = 1'b1;
        end
      end
      ST_MUTE: begin
        if (timer_done) begin
          target_d = tx_req_eff;
          // Request withdrawn while muted: nothing to move, skip straight back.
          if ((tx_req_eff == tx_q) && (cfg_tgt == applied_q))
            state_d = tx_req_eff ? ST_TX_ACT : ST_RX_ACT;
          else
            state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        target_d  = tx_req_eff;
        rx_d      = ~tx_req_eff;
        tx_d      = tx_req_eff;
        applied_d = cfg_tgt;
        state_d   = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (timer_done) state_d = target_q ? ST_TX_ACT : ST_RX_ACT;
      end
      default: state_d = ST_APPLY;
    endcase

    timer_load = 1'b0;
    timer_val  = '0;
    if ((state_d == ST_MUTE) && (state_q != ST_MUTE)) begin
      timer_load = 1'b1;
      timer_val  = CNT_W'(MUTE_CYC - 1);
    end else if ((state_d == ST_SETTLE) && (state_q != ST_SETTLE)) begin
      timer_load = 1'b1;
      timer_val  = CNT_W'(SETTLE_CYC - 1);
    end

    rx_mute_d = (state_d != ST_RX_ACT);
    tx_gate_d = (state_d == ST_TX_ACT);
    busy_d    = (state_d != ST_RX_ACT) && (state_d != ST_TX_ACT);
  end

  trx_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_APPLY;
      target_q  <= 1'b0;
      rx_q      <= 1'b1;
      tx_q      <= 1'b0;
      applied_q <= '0;
      rx_mute_q <= 1'b1;
      tx_gate_q <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      applied_q <= applied_d;
      rx_mute_q <= rx_mute_d;
      tx_gate_q <= tx_gate_d;
      busy_q    <= busy_d;
    end
  end

  assign rx          = rx_q;
  assign tx          = tx_q;
  assign att_out     = applied_q.att;
  assign preamp_out  = applied_q.preamp;
  assign bpf_out     = applied_q.bpf;
  assign lpf_out     = applied_q.lpf;
  assign rx_mute     = rx_mute_q;
  assign tx_gate     = tx_gate_q;
  assign busy        = busy_q;
  assign state_debug = state_q;

endmodule

// File: tb/tb_trx_switch_sequencer.sv
// Directed bench for trx_switch_sequencer with a phase/countdown reference model
// compared every cycle, plus literal timing checks from hand-worked latencies.
module tb_trx_switch_sequencer;

  localparam int MUTE_CYC       = 4;
  localparam int SETTLE_CYC     = 8;
  localparam int CNT_W          = 16;
  localparam int TX_TIMEOUT_CYC = 20;

  localparam int P_ACT    = 0;
  localparam int P_MUTE   = 1;
  localparam int P_APPLY  = 2;
  localparam int P_SETTLE = 3;

  logic       clk, rst_n;
  logic       tx_req;
  logic [5:0] cfg_att;
  logic       cfg_preamp;
  logic [3:0] cfg_bpf;
  logic [2:0] cfg_lpf;
  logic       rx, tx, preamp_out, rx_mute, tx_gate, busy, tx_timeout;
  logic [5:0] att_out;
  logic [3:0] bpf_out;
  logic [2:0] lpf_out;
  logic [2:0] state_debug;

  int n_cmp  = 0;
  int n_fail = 0;
  bit check_en = 0;

  // Reference model: where the sequence is, how many edges remain in a timed
  // phase, which mode the TR relay is in, and what relay word is applied.
  int          m_phase;
  int          m_left;
  bit          m_tx;
  logic [13:0] m_applied;
  bit          m_timeout;
  int          m_tx_cycles;

  trx_switch_sequencer #(
    .MUTE_CYC       (MUTE_CYC),
    .SETTLE_CYC     (SETTLE_CYC),
    .CNT_W          (CNT_W),
    .TX_TIMEOUT_CYC (TX_TIMEOUT_CYC)
  ) dut (
    .clk_in      (clk),
    .reset_n     (rst_n),
    .tx_req      (tx_req),
    .cfg_att     (cfg_att),
    .cfg_preamp  (cfg_preamp),
    .cfg_bpf     (cfg_bpf),
    .cfg_lpf     (cfg_lpf),
    .rx          (rx),
    .tx          (tx),
    .att_out     (att_out),
    .preamp_out  (preamp_out),
    .bpf_out     (bpf_out),
    .lpf_out     (lpf_out),
    .rx_mute     (rx_mute),
    .tx_gate     (tx_gate),
    .busy        (busy),
    .tx_timeout  (tx_timeout),
    .state_debug (state_debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] want_cfg(input bit to_tx);
    return {cfg_att, cfg_preamp & ~to_tx, cfg_bpf, cfg_lpf};
  endfunction

  task automatic model_reset();
    m_phase     = P_APPLY;
    m_left      = 0;
    m_tx        = 1'b0;
    m_applied   = '0;
    m_timeout   = 1'b0;
    m_tx_cycles = 0;
  endtask

  task automatic start_mute();
    m_phase = P_MUTE;
    m_left  = MUTE_CYC;
  endtask

  task automatic model_step();
    bit treq;
    bit wd_fire;
    treq    = tx_req && !m_timeout;
    wd_fire = 1'b0;
`ifdef TRX_TX_WATCHDOG_EN
    if (m_phase == P_ACT && m_tx) begin
      m_tx_cycles++;
      wd_fire = (m_tx_cycles == TX_TIMEOUT_CYC);
    end else begin
      m_tx_cycles = 0;
    end
    if (wd_fire)      m_timeout = 1'b1;
    else if (!tx_req) m_timeout = 1'b0;
`endif
    case (m_phase)
      P_ACT: begin
        if (!m_tx) begin
          if (treq || want_cfg(1'b0) != m_applied) start_mute();
        end else begin
          if (wd_fire || !treq || want_cfg(1'b1) != m_applied) start_mute();
        end
      end
      P_MUTE: begin
        m_left--;
        if (m_left == 0) begin
          if (treq == m_tx && want_cfg(treq) == m_applied) m_phase = P_ACT;
          else                                             m_phase = P_APPLY;
        end
      end
      P_APPLY: begin
        m_tx      = treq;
        m_applied = want_cfg(treq);
        m_phase   = P_SETTLE;
        m_left    = SETTLE_CYC;
      end
      default: begin
        m_left--;
        if (m_left == 0) m_phase = P_ACT;
      end
    endcase
  endtask

  function automatic logic [19:0] exp_vec();
    bit act_rx, act_tx;
    act_rx = (m_phase == P_ACT) && !m_tx;
    act_tx = (m_phase == P_ACT) && m_tx;
    return {~m_tx, m_tx, m_applied, ~act_rx, act_tx, (m_phase != P_ACT), m_timeout};
  endfunction

  function automatic logic [19:0] dut_vec();
    return {rx, tx, att_out, preamp_out, bpf_out, lpf_out, rx_mute, tx_gate, busy, tx_timeout};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial begin
    rst_n      = 1'b0;
    tx_req     = 1'b0;
    cfg_att    = 6'b000000;
    cfg_preamp = 1'b1;
    cfg_bpf    = 4'b0011;
    cfg_lpf    = 3'b010;

    fork
      forever begin
        @(negedge clk);
        if (check_en) begin
          n_cmp++;
          if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL cycle_compare t=%0t dut=%h model=%h", $time, dut_vec(), exp_vec());
          end
        end
      end
    join_none

    step(1);
    check_en = 1'b1;
    step(2);
    check("rst_rx", rx, 1);
    check("rst_tx", tx, 0);
    check("rst_busy", busy, 1);
    check("rst_rx_mute", rx_mute, 1);
    check("rst_lpf_out", lpf_out, 0);

    // Power-up: apply then full settle before RX_ACT.
    rst_n = 1'b1;
    step(8);
    check("pwr_busy_still", busy, 1);
    step(1);
    check("pwr_busy_done", busy, 0);
    check("pwr_lpf_out", lpf_out, 3'b010);
    check("pwr_rx", rx, 1);
    check("pwr_rx_mute", rx_mute, 0);
    check("pwr_preamp", preamp_out, 1);
    check("model_pwr_phase", m_phase, P_ACT);
    step(2);

    // RX -> TX latency.
    tx_req = 1'b1;
    step(1);
    check("rxtx_mute_e0", rx_mute, 1);
    check("rxtx_rx_e0", rx, 1);
    step(4);
    check("rxtx_rx_e4", rx, 1);
    check("rxtx_tx_e4", tx, 0);
    step(1);
    check("rxtx_tx_e5", tx, 1);
    check("rxtx_rx_e5", rx, 0);
    check("rxtx_preamp_e5", preamp_out, 0);
    step(7);
    check("rxtx_gate_e12", tx_gate, 0);
    step(1);
    check("rxtx_gate_e13", tx_gate, 1);
    check("rxtx_busy_e13", busy, 0);
    check("model_tx_mode", m_tx, 1);
    step(3);

    // TX -> RX.
    tx_req = 1'b0;
    step(14);
    check("txrx_busy", busy, 0);
    check("txrx_rx", rx, 1);
    check("txrx_rx_mute", rx_mute, 0);
    check("txrx_preamp", preamp_out, 1);
    step(2);

    // Attenuator change in RX.
    cfg_att = 6'b000100;
    step(13);
    check("att_busy_e12", busy, 1);
    step(1);
    check("att_busy_e13", busy, 0);
    check("att_out", att_out, 6'b000100);
    check("att_rx", rx, 1);
    step(2);

    // Short TX request pulse aborts after the mute.
    tx_req = 1'b1;
    step(2);
    tx_req = 1'b0;
    step(2);
    check("pulse_busy_e3", busy, 1);
    step(1);
    check("pulse_busy_e4", busy, 0);
    check("pulse_rx_mute", rx_mute, 0);
    check("pulse_tx", tx, 0);
    step(2);

    // Reset during SETTLE of RX -> TX.
    tx_req = 1'b1;
    step(8);
    check("mid_tx_before", tx, 1);
    check("mid_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rx", rx, 1);
    check("mid_rst_tx", tx, 0);
    check("mid_rst_gate", tx_gate, 0);
    check("mid_rst_mute", rx_mute, 1);
    check("mid_rst_att", att_out, 0);
    tx_req = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(8);
    check("mid_rec_busy", busy, 1);
    check("mid_rec_gate", tx_gate, 0);
    step(1);
    check("mid_rec_done", busy, 0);
    check("mid_rec_rx", rx, 1);
    check("mid_rec_att", att_out, 6'b000100);
    step(2);

`ifdef TRX_TX_WATCHDOG_EN
    // Watchdog: 20 TX_ACT cycles then forced back to RX.
    tx_req = 1'b1;
    step(14);
    check("wd_tx_gate", tx_gate, 1);
    step(19);
    check("wd_not_yet", tx_timeout, 0);
    step(1);
    check("wd_fired", tx_timeout, 1);
    check("wd_gate_off", tx_gate, 0);
    step(13);
    check("wd_rx_busy", busy, 0);
    check("wd_rx", rx, 1);
    check("wd_flag_held", tx_timeout, 1);
    step(3);
    tx_req = 1'b0;
    step(1);
    check("wd_cleared", tx_timeout, 0);
    step(2);
`endif

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
